// File: rtl/mem_arbiter_if.sv
// Bus bundle between the I/D request sides, the arbiter and the backing memory port.
interface mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_cancel;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;

  modport slave (
    input  i_req, i_addr, i_cancel, d_req, d_we, d_addr, d_wdata, d_wstrb,
           mem_ack, mem_rdata,
    output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, busy
  );

  modport master (
    output i_req, i_addr, i_cancel, d_req, d_we, d_addr, d_wdata, d_wstrb,
           mem_ack, mem_rdata,
    input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between icache refill (I) and dcache (D).
// IDLE: no transaction, grant pending side | ISSUE: mem_req pulse | WAIT: await mem_ack or timeout
module mem_arbiter #(
  parameter int          TIMEOUT = 64,
  parameter logic [31:0] NOP     = 32'h0000_0013
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.slave  io_bus
);
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  state_t      r_state, w_next;
  logic        r_i_pend, r_d_pend, r_owner_d, r_last_d, r_squash;
  logic [31:0] r_i_addr, r_d_addr, r_d_wdata;
  logic        r_d_we;
  logic [3:0]  r_d_wstrb;
  logic [CW-1:0] r_cnt;
  logic        r_i_ack, r_i_err, r_d_ack, r_d_err;
  logic [31:0] r_i_rdata, r_d_rdata;
  logic        r_mem_we;
  logic [31:0] r_mem_addr, r_mem_wdata;
  logic [3:0]  r_mem_wstrb;

  logic w_i_fly, w_d_fly, w_i_cand, w_i_take, w_d_take, w_squash_now;
  logic w_grant, w_grant_d, w_done, w_tmo;

  assign w_i_fly      = (r_state != ST_IDLE) && !r_owner_d;
  assign w_d_fly      = (r_state != ST_IDLE) && r_owner_d;
  // A cancel arriving on the grant edge withdraws the pending I request before it is issued.
  assign w_i_cand     = r_i_pend && !io_bus.i_cancel;
  assign w_i_take     = io_bus.i_req &&
                        (io_bus.i_cancel || !(r_i_pend || (w_i_fly && !r_squash)));
  assign w_d_take     = io_bus.d_req && !(r_d_pend || w_d_fly);
  assign w_squash_now = r_squash || io_bus.i_cancel;

  always_comb begin
    w_next    = r_state;
    w_grant   = 1'b0;
    w_grant_d = 1'b0;
    w_done    = 1'b0;
    w_tmo     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_i_cand || r_d_pend) begin
          w_grant   = 1'b1;
          w_grant_d = r_d_pend && (!w_i_cand || !r_last_d);
          w_next    = ST_ISSUE;
        end
      end
      ST_ISSUE: w_next = ST_WAIT;
      ST_WAIT: begin
        if (io_bus.mem_ack) begin
          w_done = 1'b1;
          w_next = ST_IDLE;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_done = 1'b1;
          w_tmo  = 1'b1;
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_i_pend    <= 1'b0;
      r_d_pend    <= 1'b0;
      r_owner_d   <= 1'b0;
      r_last_d    <= 1'b1;
      r_squash    <= 1'b0;
      r_i_addr    <= '0;
      r_d_addr    <= '0;
      r_d_wdata   <= '0;
      r_d_we      <= 1'b0;
      r_d_wstrb   <= '0;
      r_cnt       <= '0;
      r_i_ack     <= 1'b0;
      r_i_err     <= 1'b0;
      r_d_ack     <= 1'b0;
      r_d_err     <= 1'b0;
      r_i_rdata   <= NOP;
      r_d_rdata   <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
    end else begin
      r_state <= w_next;
      r_i_ack <= 1'b0;
      r_i_err <= 1'b0;
      r_d_ack <= 1'b0;
      r_d_err <= 1'b0;

      if (w_i_take) begin
        r_i_pend <= 1'b1;
        r_i_addr <= io_bus.i_addr;
      end else if (io_bus.i_cancel || (w_grant && !w_grant_d)) begin
        r_i_pend <= 1'b0;
      end

      if (w_d_take) begin
        r_d_pend  <= 1'b1;
        r_d_we    <= io_bus.d_we;
        r_d_addr  <= io_bus.d_addr;
        r_d_wdata <= io_bus.d_wdata;
        r_d_wstrb <= io_bus.d_wstrb;
      end else if (w_grant && w_grant_d) begin
        r_d_pend <= 1'b0;
      end

      if (w_grant) begin
        r_owner_d   <= w_grant_d;
        r_last_d    <= w_grant_d;
        r_mem_we    <= w_grant_d ? r_d_we : 1'b0;
        r_mem_addr  <= w_grant_d ? r_d_addr : r_i_addr;
        r_mem_wdata <= w_grant_d ? r_d_wdata : 32'h0;
        r_mem_wstrb <= w_grant_d ? r_d_wstrb : 4'h0;
      end

      if (r_state == ST_ISSUE)     r_cnt <= '0;
      else if (r_state == ST_WAIT) r_cnt <= r_cnt + CW'(1);

      if (w_done)                        r_squash <= 1'b0;
      else if (io_bus.i_cancel && w_i_fly) r_squash <= 1'b1;

      if (w_done) begin
        if (r_owner_d) begin
          r_d_ack   <= 1'b1;
          r_d_err   <= w_tmo;
          r_d_rdata <= (w_tmo || r_mem_we) ? 32'h0 : io_bus.mem_rdata;
        end else if (!w_squash_now) begin
          r_i_ack   <= 1'b1;
          r_i_err   <= w_tmo;
          r_i_rdata <= w_tmo ? NOP : io_bus.mem_rdata;
        end
      end
    end
  end

  assign io_bus.mem_req   = (r_state == ST_ISSUE);
  assign io_bus.busy      = (r_state != ST_IDLE);
  assign io_bus.mem_we    = r_mem_we;
  assign io_bus.mem_addr  = r_mem_addr;
  assign io_bus.mem_wdata = r_mem_wdata;
  assign io_bus.mem_wstrb = r_mem_wstrb;
  assign io_bus.i_ack     = r_i_ack;
  assign io_bus.i_rdata   = r_i_rdata;
  assign io_bus.i_err     = r_i_err;
  assign io_bus.d_ack     = r_d_ack;
  assign io_bus.d_rdata   = r_d_rdata;
  assign io_bus.d_err     = r_d_err;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: arbitration order, writes, cancel, timeout and reset.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0, n_mreq = 0, n_iack = 0, n_dack = 0;

  mem_arbiter_if bus ();

  mem_arbiter #(.TIMEOUT(8), .NOP(32'h0000_0013)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (bus.mem_req) n_mreq++;
    if (bus.i_ack)   n_iack++;
    if (bus.d_ack)   n_dack++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits for the grant, checks the issued command, then acks one cycle into WAIT.
  task automatic serve(input string tag, input logic [31:0] addr, input logic we,
                       input logic [31:0] rdata);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!bus.mem_req && n < 20);
    chk({tag, "_mem_req"}, bus.mem_req, 1);
    chk({tag, "_mem_addr"}, bus.mem_addr, addr);
    chk({tag, "_mem_we"}, bus.mem_we, we);
    tick();
    bus.mem_ack = 1'b1;
    bus.mem_rdata = rdata;
    tick();
    bus.mem_ack = 1'b0;
  endtask

  initial begin
    int t0, snap, early;
    bus.i_req = 0; bus.i_addr = 0; bus.i_cancel = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.d_wstrb = 0;
    bus.mem_ack = 0; bus.mem_rdata = 0;
    tick(); tick();
    chk("rst_i_rdata", bus.i_rdata, 32'h13);
    chk("rst_d_rdata", bus.d_rdata, 32'h0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_acks", {bus.i_ack, bus.d_ack, bus.i_err, bus.d_err}, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    rst = 1'b1;
    tick();

    // Simultaneous pair after reset: I wins the first tie
    bus.i_req = 1; bus.i_addr = 32'h44;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h100;
    tick();
    bus.i_req = 0; bus.d_req = 0;
    serve("p1i", 32'h44, 0, 32'hA1);
    chk("p1i_ack", bus.i_ack, 1);
    chk("p1i_rdata", bus.i_rdata, 32'hA1);
    chk("p1i_d_ack", bus.d_ack, 0);
    serve("p1d", 32'h100, 0, 32'hB2);
    chk("p1d_ack", bus.d_ack, 1);
    chk("p1d_rdata", bus.d_rdata, 32'hB2);
    chk("p1d_err", bus.d_err, 0);

    // Lone I read, minimum latency
    snap = n_mreq;
    bus.i_req = 1; bus.i_addr = 32'h40;
    tick();
    t0 = cyc;
    bus.i_req = 0;
    chk("t1_no_early_req", bus.mem_req, 0);
    serve("t1", 32'h40, 0, 32'h40);
    chk("t1_latency", cyc - t0, 3);
    chk("t1_ack", bus.i_ack, 1);
    chk("t1_rdata", bus.i_rdata, 32'h40);
    chk("t1_err", bus.i_err, 0);
    chk("t1_one_mem_req", n_mreq - snap, 1);
    tick();
    chk("t1_ack_pulse", bus.i_ack, 0);
    chk("t1_rdata_held", bus.i_rdata, 32'h40);

    // Cancel of in-flight I with a same-cycle replacement request
    snap = n_iack;
    bus.i_req = 1; bus.i_addr = 32'h08;
    tick();
    bus.i_req = 0;
    tick();
    chk("cx_first_addr", bus.mem_addr, 32'h08);
    bus.i_cancel = 1; bus.i_req = 1; bus.i_addr = 32'h44;
    tick();
    bus.i_cancel = 0; bus.i_req = 0;
    bus.mem_ack = 1; bus.mem_rdata = 32'h08;
    tick();
    bus.mem_ack = 0;
    chk("cx_squashed_ack", bus.i_ack, 0);
    serve("cx", 32'h44, 0, 32'h44);
    chk("cx_ack", bus.i_ack, 1);
    chk("cx_rdata", bus.i_rdata, 32'h44);
    tick();
    chk("cx_single_ack", n_iack - snap, 1);

    // D write, fields held through WAIT
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h200;
    bus.d_wdata = 32'hDEADBEEF; bus.d_wstrb = 4'b0011;
    tick();
    bus.d_req = 0; bus.d_we = 0; bus.d_wdata = 0; bus.d_wstrb = 0;
    tick();
    chk("wr_mem_req", bus.mem_req, 1);
    chk("wr_mem_we", bus.mem_we, 1);
    chk("wr_mem_addr", bus.mem_addr, 32'h200);
    chk("wr_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    chk("wr_mem_wstrb", bus.mem_wstrb, 4'b0011);
    tick(); tick();
    chk("wr_hold_req_low", bus.mem_req, 0);
    chk("wr_hold_busy", bus.busy, 1);
    chk("wr_hold_wdata", bus.mem_wdata, 32'hDEADBEEF);
    chk("wr_hold_wstrb", bus.mem_wstrb, 4'b0011);
    chk("wr_hold_we", bus.mem_we, 1);
    bus.mem_ack = 1; bus.mem_rdata = 32'h5555_5555;
    tick();
    bus.mem_ack = 0;
    chk("wr_d_ack", bus.d_ack, 1);
    chk("wr_d_rdata", bus.d_rdata, 32'h0);
    chk("wr_d_err", bus.d_err, 0);

    // Watchdog: memory never answers
    bus.i_req = 1; bus.i_addr = 32'h80;
    tick();
    bus.i_req = 0;
    tick();
    chk("to_mem_req", bus.mem_req, 1);
    tick();
    early = 0;
    for (int k = 0; k < 7; k++) begin
      tick();
      if (bus.i_ack) early++;
    end
    chk("to_no_early_ack", early, 0);
    tick();
    chk("to_ack", bus.i_ack, 1);
    chk("to_err", bus.i_err, 1);
    chk("to_rdata_nop", bus.i_rdata, 32'h13);
    bus.mem_ack = 1; bus.mem_rdata = 32'h77;
    tick();
    bus.mem_ack = 0;
    chk("late_ack_i", bus.i_ack, 0);
    chk("late_ack_d", bus.d_ack, 0);
    chk("late_ack_busy", bus.busy, 0);
    tick();
    chk("late_ack_no_req", bus.mem_req, 0);

    // Second simultaneous pair: D wins after an I grant
    bus.i_req = 1; bus.i_addr = 32'h48;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h104;
    tick();
    bus.i_req = 0; bus.d_req = 0;
    serve("p2d", 32'h104, 0, 32'hC3);
    chk("p2d_ack", bus.d_ack, 1);
    chk("p2d_rdata", bus.d_rdata, 32'hC3);
    serve("p2i", 32'h48, 0, 32'hD4);
    chk("p2i_ack", bus.i_ack, 1);
    chk("p2i_rdata", bus.i_rdata, 32'hD4);

    // Reset in the middle of a D WAIT
    snap = n_dack;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h300;
    tick();
    bus.d_req = 0;
    tick(); tick(); tick();
    chk("mr_busy_before", bus.busy, 1);
    rst = 1'b0;
    bus.mem_ack = 1; bus.mem_rdata = 32'h99;
    tick();
    rst = 1'b1;
    bus.mem_ack = 0;
    chk("mr_busy", bus.busy, 0);
    chk("mr_mem_req", bus.mem_req, 0);
    chk("mr_mem_addr", bus.mem_addr, 0);
    chk("mr_mem_we", bus.mem_we, 0);
    chk("mr_i_rdata", bus.i_rdata, 32'h13);
    chk("mr_d_rdata", bus.d_rdata, 32'h0);
    chk("mr_d_ack", bus.d_ack, 0);
    tick(); tick();
    chk("mr_no_d_ack", n_dack - snap, 0);
    bus.i_req = 1; bus.i_addr = 32'h60;
    tick();
    bus.i_req = 0;
    serve("post", 32'h60, 0, 32'h60);
    chk("post_ack", bus.i_ack, 1);
    chk("post_rdata", bus.i_rdata, 32'h60);
    chk("post_err", bus.i_err, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
